match_judge: RTL and testbench
==============================

Name: match_judge

Overview:
- Producer end of the 2-bit matchresult interface consumed by the score/round counters.
- Collects one rock-paper-scissors move from each player and compares them.
- Emits exactly one single-cycle result code per round, so downstream counters advance once per round.
- Handles forfeit by timeout, a post-result holdoff, and optional match-end detection.

Parameters:
- TIMEOUT, 16: cycles allowed after the first player locks before the other forfeits; 0 disables forfeit.
- HOLDOFF, 4: cycles after the result pulse during which moves are ignored; legal range 1..255.
- WIN_TARGET, 3: round wins that end the match; used only with MATCH_END_EN.

Ports:
clk  input  1  system clock, all logic on posedge
resetn  input  1  synchronous active-low reset
p1_move  input  2  player 1 move: 01 rock, 10 paper, 11 scissors, 00 none
p1_valid  input  1  player 1 move strobe
p2_move  input  2  player 2 move, same encoding
p2_valid  input  1  player 2 move strobe
ready  output  1  high when state is COLLECT (moves accepted)
p1_locked  output  1  player 1 move captured this round
p2_locked  output  1  player 2 move captured this round
matchresult  output  2  00 idle, 01 draw, 10 p1 wins, 11 p2 wins; non-zero for exactly one cycle per round
result_valid  output  1  high in the same cycle matchresult is non-zero
last_result  output  2  most recent non-idle result, held until the next one
game_over  output  1  match finished (MATCH_END_EN only; tied 0 otherwise)

Behaviour:
- One clock (clk). Reset is synchronous, active-low, on resetn.
- Reset (resetn=0 at a posedge) forces:
  - state=COLLECT;
  - ready=1 from the first cycle after reset;
  - locks, timers, matchresult, result_valid, last_result and game_over all cleared to 0.
- Reset mid-round discards captured moves; no result pulse is produced.
- States: COLLECT, JUDGE, RESULT, HOLD.
- COLLECT:
  - A player's move is captured when its valid=1, move!=00 and it is not yet locked. Capture sets that player's lock.
  - A valid strobe with move=00 is ignored.
  - Strobes from an already-locked player are ignored; the first move wins.
  - Both players valid in the same cycle: both are captured; next state is JUDGE.
  - Both locked: next state is JUDGE.
  - Timeout counter:
    - Clears to 0 in the cycle the first lock occurs, then increments each cycle while exactly one player is locked.
    - When the counter equals TIMEOUT-1 and the other player is still unlocked, the round is a forfeit in favour of the locked player. Next state is RESULT with code 10 or 11.
  - TIMEOUT=0: wait indefinitely.
- JUDGE (1 cycle):
  - Equal moves give 01.
  - Player 1 wins (10) when: rock vs scissors, paper vs rock, or scissors vs paper.
  - Otherwise player 2 wins (11).
  - The result is registered; next state is RESULT.
- RESULT (1 cycle):
  - matchresult=code, result_valid=1, last_result<=code.
  - Locks are cleared; next state is HOLD.
- Latency: moves completing the pair sampled at edge T give JUDGE during cycle T+1 and matchresult valid during cycle T+2. A forfeit gives matchresult valid in the cycle after the timeout edge.
- HOLD:
  - ready=0; inputs are ignored.
  - Lasts HOLDOFF cycles, then returns to COLLECT.
- Outside RESULT, matchresult=00 and result_valid=0. All outputs are registered.

Optional Feature:
- Macro: MATCH_END_EN.
- Defined:
  - Two internal 8-bit win tallies, incremented on codes 10 and 11 respectively; draws are not counted.
  - When either tally reaches WIN_TARGET, game_over=1 from the cycle after the RESULT cycle.
  - The HOLD state then transitions to a terminal DONE state: ready=0, inputs ignored, no further result pulses.
  - DONE exits only by reset, which clears the tallies and game_over.
- Undefined: no tallies, no DONE state, game_over tied 0. The block judges rounds indefinitely.

Test Plan:
1. p1_move=01 with p1_valid at cycle 0; p2_move=11 with p2_valid at cycle 3 -> matchresult=10 and result_valid=1 for exactly one cycle at cycle 5; last_result=10 afterwards; ready=0 for HOLDOFF=4 cycles, then 1.
2. Both players strobe 10 in the same cycle -> one-cycle matchresult=01 two cycles later; neither win tally moves.
3. p1 strobes 11, then strobes 01 one cycle later; p2 strobes 10 -> the second p1 strobe is ignored, result=10 (scissors beats paper).
4. TIMEOUT=16: p2 locks 01 and p1 stays silent -> matchresult=11 exactly once, 16 cycles after the lock edge; p1 strobes during HOLD are ignored.
5. Strobe move=00 on p1_valid -> p1_locked stays 0; no result is ever produced.
6. resetn=0 for one cycle while p1 is locked -> all outputs 0 and no result pulse. With MATCH_END_EN and WIN_TARGET=3: three p1 wins -> game_over=1, ready stays 0, and further strobes produce no pulse.

Source files
------------

// File: rtl/match_judge.sv
// Rock-paper-scissors round judge driving the 2-bit matchresult interface.
// Optional match-end detection (win tallies, terminal DONE state) is built when MATCH_END_EN is defined.
module match_judge #(
  parameter int TIMEOUT    = 16,
  parameter int HOLDOFF    = 4,
  parameter int WIN_TARGET = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic       ready,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic [1:0] matchresult,
  output logic       result_valid,
  output logic [1:0] last_result,
  output logic       game_over
);

  // state     | meaning
  // S_COLLECT | accepting moves, forfeit timer runs while one player is locked
  // S_JUDGE   | both moves held, compare them
  // S_RESULT  | one-cycle result pulse, locks released
  // S_HOLD    | post-result holdoff, inputs ignored
  // S_DONE    | match finished, waits for reset (MATCH_END_EN only)
  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_JUDGE   = 3'd1,
    S_RESULT  = 3'd2,
    S_HOLD    = 3'd3
`ifdef MATCH_END_EN
    , S_DONE  = 3'd4
`endif
  } state_t;

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLDOFF - 1);

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b01;
    if ((a == 2'b01 && b == 2'b11) ||
        (a == 2'b10 && b == 2'b01) ||
        (a == 2'b11 && b == 2'b10)) return 2'b10;
    return 2'b11;
  endfunction

  state_t      state_q, state_d;
  logic        p1_locked_q, p1_locked_d;
  logic        p2_locked_q, p2_locked_d;
  logic [1:0]  p1_mv_q, p1_mv_d;
  logic [1:0]  p2_mv_q, p2_mv_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        ready_q, ready_d;
  logic [1:0]  matchresult_q, matchresult_d;
  logic        result_valid_q, result_valid_d;
  logic [1:0]  last_result_q, last_result_d;

`ifdef MATCH_END_EN
  localparam logic [7:0] WIN_TGT = 8'(WIN_TARGET);
  logic [7:0] p1_wins_q, p1_wins_d;
  logic [7:0] p2_wins_q, p2_wins_d;
  logic       game_over_q, game_over_d;
`endif

  always_comb begin
    state_d       = state_q;
    p1_locked_d   = p1_locked_q;
    p2_locked_d   = p2_locked_q;
    p1_mv_d       = p1_mv_q;
    p2_mv_d       = p2_mv_q;
    to_cnt_d      = 16'd0;
    hold_cnt_d    = hold_cnt_q;
    matchresult_d = 2'b00;
    last_result_d = last_result_q;

    case (state_q)
      S_COLLECT: begin
        if (p1_valid && p1_move != 2'b00 && !p1_locked_q) begin
          p1_locked_d = 1'b1;
          p1_mv_d     = p1_move;
        end
        if (p2_valid && p2_move != 2'b00 && !p2_locked_q) begin
          p2_locked_d = 1'b1;
          p2_mv_d     = p2_move;
        end
        // A completing move on the timeout edge still wins over the forfeit.
        if (p1_locked_d && p2_locked_d) begin
          state_d = S_JUDGE;
        end else if (p1_locked_q ^ p2_locked_q) begin
          if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
            state_d       = S_RESULT;
            matchresult_d = p1_locked_q ? 2'b10 : 2'b11;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
      end
      S_JUDGE: begin
        matchresult_d = judge(p1_mv_q, p2_mv_q);
        state_d       = S_RESULT;
      end
      S_RESULT: begin
        p1_locked_d = 1'b0;
        p2_locked_d = 1'b0;
        hold_cnt_d  = HOLD_LAST;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == 8'd0) begin
`ifdef MATCH_END_EN
          state_d = game_over_q ? S_DONE : S_COLLECT;
`else
          state_d = S_COLLECT;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
`ifdef MATCH_END_EN
      S_DONE: state_d = S_DONE;
`endif
      default: state_d = S_COLLECT;
    endcase

    result_valid_d = (matchresult_d != 2'b00);
    if (result_valid_d) last_result_d = matchresult_d;
    ready_d = (state_d == S_COLLECT);

`ifdef MATCH_END_EN
    p1_wins_d   = p1_wins_q;
    p2_wins_d   = p2_wins_q;
    game_over_d = game_over_q;
    if (matchresult_d == 2'b10) p1_wins_d = p1_wins_q + 8'd1;
    if (matchresult_d == 2'b11) p2_wins_d = p2_wins_q + 8'd1;
    if (state_q == S_RESULT && (p1_wins_q >= WIN_TGT || p2_wins_q >= WIN_TGT))
      game_over_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_COLLECT;
      p1_locked_q    <= 1'b0;
      p2_locked_q    <= 1'b0;
      p1_mv_q        <= 2'b00;
      p2_mv_q        <= 2'b00;
      to_cnt_q       <= 16'd0;
      hold_cnt_q     <= 8'd0;
      ready_q        <= 1'b1;
      matchresult_q  <= 2'b00;
      result_valid_q <= 1'b0;
      last_result_q  <= 2'b00;
    end else begin
      state_q        <= state_d;
      p1_locked_q    <= p1_locked_d;
      p2_locked_q    <= p2_locked_d;
      p1_mv_q        <= p1_mv_d;
      p2_mv_q        <= p2_mv_d;
      to_cnt_q       <= to_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      ready_q        <= ready_d;
      matchresult_q  <= matchresult_d;
      result_valid_q <= result_valid_d;
      last_result_q  <= last_result_d;
    end
  end

`ifdef MATCH_END_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p1_wins_q   <= 8'd0;
      p2_wins_q   <= 8'd0;
      game_over_q <= 1'b0;
    end else begin
      p1_wins_q   <= p1_wins_d;
      p2_wins_q   <= p2_wins_d;
      game_over_q <= game_over_d;
    end
  end
  assign game_over = game_over_q;
`else
  assign game_over = 1'b0;
`endif

  assign ready        = ready_q;
  assign p1_locked    = p1_locked_q;
  assign p2_locked    = p2_locked_q;
  assign matchresult  = matchresult_q;
  assign result_valid = result_valid_q;
  assign last_result  = last_result_q;

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge with default parameters (TIMEOUT=16, HOLDOFF=4, WIN_TARGET=3).
module tb_match_judge;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic       p1_valid = 1'b0;
  logic [1:0] p2_move = 2'b00;
  logic       p2_valid = 1'b0;
  logic       ready, p1_locked, p2_locked, result_valid, game_over;
  logic [1:0] matchresult, last_result;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;
  int pc;

  match_judge dut (
    .clk(clk), .resetn(resetn),
    .p1_move(p1_move), .p1_valid(p1_valid),
    .p2_move(p2_move), .p2_valid(p2_valid),
    .ready(ready), .p1_locked(p1_locked), .p2_locked(p2_locked),
    .matchresult(matchresult), .result_valid(result_valid),
    .last_result(last_result), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) pulse_cnt++;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p1_valid = 1'b0; p1_move = 2'b00;
    p2_valid = 1'b0; p2_move = 2'b00;
  endtask

  task automatic wait_collect(input string name);
    for (int i = 0; i < 20 && ready !== 1'b1; i++) cyc();
    cmp_cnt++;
    if (ready !== 1'b1) begin err_cnt++; $display("FAIL %s wait_collect: ready=%b required 1", name, ready); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(); cyc();
    cmp_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL reset ready: got %b want 1", ready); end
    cmp_cnt++; if (p1_locked !== 1'b0 || p2_locked !== 1'b0) begin err_cnt++; $display("FAIL reset locks: got %b%b want 00", p1_locked, p2_locked); end
    cmp_cnt++; if (matchresult !== 2'b00 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL reset result: got %b/%b want 00/0", matchresult, result_valid); end
    cmp_cnt++; if (last_result !== 2'b00) begin err_cnt++; $display("FAIL reset last_result: got %b want 00", last_result); end
    cmp_cnt++; if (game_over !== 1'b0) begin err_cnt++; $display("FAIL reset game_over: got %b want 0", game_over); end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_basic_round();
    p1_valid = 1'b1; p1_move = 2'b01;
    cyc();
    idle_inputs();
    cmp_cnt++; if (p1_locked !== 1'b1 || p2_locked !== 1'b0) begin err_cnt++; $display("FAIL basic lock: got %b%b want 10", p1_locked, p2_locked); end
    cmp_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL basic ready_collect: got %b want 1", ready); end
    cyc(); cyc();
    p2_valid = 1'b1; p2_move = 2'b11;
    cyc();
    idle_inputs();
    cmp_cnt++; if (result_valid !== 1'b0 || ready !== 1'b0) begin err_cnt++; $display("FAIL basic judge_cycle: valid=%b ready=%b want 0/0", result_valid, ready); end
    cyc();
    cmp_cnt++; if (matchresult !== 2'b10 || result_valid !== 1'b1) begin err_cnt++; $display("FAIL basic result: got %b/%b want 10/1", matchresult, result_valid); end
    pc = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc();
      cmp_cnt++; if (ready !== 1'b0 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL basic hold%0d: ready=%b valid=%b want 0/0", i, ready, result_valid); end
    end
    cmp_cnt++; if (last_result !== 2'b10 || matchresult !== 2'b00) begin err_cnt++; $display("FAIL basic last_result: got %b mr=%b want 10/00", last_result, matchresult); end
    cyc();
    cmp_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL basic ready_back: got %b want 1", ready); end
    cmp_cnt++; if (pulse_cnt !== pc) begin err_cnt++; $display("FAIL basic single_pulse: got %0d pulses after, want %0d", pulse_cnt, pc); end
  endtask

  task automatic test_draw();
    p1_valid = 1'b1; p1_move = 2'b10;
    p2_valid = 1'b1; p2_move = 2'b10;
    cyc();
    idle_inputs();
    cmp_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL draw early: got %b want 0", result_valid); end
    cyc();
    cmp_cnt++; if (matchresult !== 2'b01 || result_valid !== 1'b1) begin err_cnt++; $display("FAIL draw result: got %b/%b want 01/1", matchresult, result_valid); end
    wait_collect("draw");
  endtask

  task automatic test_first_move_wins();
    p1_valid = 1'b1; p1_move = 2'b11;
    cyc();
    p1_move = 2'b01;
    cyc();
    idle_inputs();
    cmp_cnt++; if (p1_locked !== 1'b1 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL first_move lock: locked=%b valid=%b want 1/0", p1_locked, result_valid); end
    p2_valid = 1'b1; p2_move = 2'b10;
    cyc();
    idle_inputs();
    cyc();
    cmp_cnt++; if (matchresult !== 2'b10) begin err_cnt++; $display("FAIL first_move result: got %b want 10", matchresult); end
    wait_collect("first_move");
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    p2_valid = 1'b1; p2_move = 2'b01;
    cyc();
    idle_inputs();
    cmp_cnt++; if (p2_locked !== 1'b1 || p1_locked !== 1'b0) begin err_cnt++; $display("FAIL timeout lock: got %b%b want 01", p1_locked, p2_locked); end
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (result_valid !== 1'b0) early = 1'b1;
    end
    cmp_cnt++; if (early !== 1'b0) begin err_cnt++; $display("FAIL timeout early: result before 16 cycles, want none"); end
    cyc();
    cmp_cnt++; if (matchresult !== 2'b11 || result_valid !== 1'b1) begin err_cnt++; $display("FAIL timeout forfeit: got %b/%b want 11/1", matchresult, result_valid); end
    pc = pulse_cnt;
    p1_valid = 1'b1; p1_move = 2'b01;
    cyc(); cyc();
    idle_inputs();
    cmp_cnt++; if (p1_locked !== 1'b0) begin err_cnt++; $display("FAIL timeout hold_strobe: p1_locked=%b want 0", p1_locked); end
    wait_collect("timeout");
    cyc(); cyc(); cyc();
    cmp_cnt++; if (p1_locked !== 1'b0 || pulse_cnt !== pc) begin err_cnt++; $display("FAIL timeout after: locked=%b pulses=%0d want 0/%0d", p1_locked, pulse_cnt, pc); end
  endtask

  task automatic test_none_move();
    pc = pulse_cnt;
    p1_valid = 1'b1; p1_move = 2'b00;
    cyc();
    idle_inputs();
    cmp_cnt++; if (p1_locked !== 1'b0) begin err_cnt++; $display("FAIL none_move lock: got %b want 0", p1_locked); end
    repeat (20) cyc();
    cmp_cnt++; if (pulse_cnt !== pc || ready !== 1'b1) begin err_cnt++; $display("FAIL none_move quiet: pulses=%0d ready=%b want %0d/1", pulse_cnt, ready, pc); end
  endtask

  task automatic test_reset_mid();
    p1_valid = 1'b1; p1_move = 2'b10;
    cyc();
    idle_inputs();
    cmp_cnt++; if (p1_locked !== 1'b1) begin err_cnt++; $display("FAIL reset_mid lock: got %b want 1", p1_locked); end
    resetn = 1'b0;
    cyc();
    cmp_cnt++; if (p1_locked !== 1'b0 || ready !== 1'b1) begin err_cnt++; $display("FAIL reset_mid state: locked=%b ready=%b want 0/1", p1_locked, ready); end
    cmp_cnt++; if (last_result !== 2'b00 || matchresult !== 2'b00 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_mid outputs: last=%b mr=%b v=%b want 00/00/0", last_result, matchresult, result_valid); end
    resetn = 1'b1;
    pc = pulse_cnt;
    repeat (20) cyc();
    cmp_cnt++; if (pulse_cnt !== pc || p1_locked !== 1'b0) begin err_cnt++; $display("FAIL reset_mid quiet: pulses=%0d locked=%b want %0d/0", pulse_cnt, p1_locked, pc); end
  endtask

  task automatic test_match_end();
    for (int r = 0; r < 3; r++) begin
      p1_valid = 1'b1; p1_move = 2'b01;
      p2_valid = 1'b1; p2_move = 2'b11;
      cyc();
      idle_inputs();
      cyc();
      cmp_cnt++; if (matchresult !== 2'b10 || result_valid !== 1'b1) begin err_cnt++; $display("FAIL match_end round%0d: got %b/%b want 10/1", r, matchresult, result_valid); end
      if (r < 2) wait_collect("match_end");
    end
    cyc();
`ifdef MATCH_END_EN
    cmp_cnt++; if (game_over !== 1'b1) begin err_cnt++; $display("FAIL match_end game_over: got %b want 1", game_over); end
    repeat (8) cyc();
    pc = pulse_cnt;
    p1_valid = 1'b1; p1_move = 2'b10;
    p2_valid = 1'b1; p2_move = 2'b01;
    cyc();
    idle_inputs();
    cyc(); cyc();
    cmp_cnt++; if (ready !== 1'b0 || game_over !== 1'b1 || pulse_cnt !== pc) begin err_cnt++; $display("FAIL match_end done: ready=%b go=%b pulses=%0d want 0/1/%0d", ready, game_over, pulse_cnt, pc); end
`else
    cmp_cnt++; if (game_over !== 1'b0) begin err_cnt++; $display("FAIL match_end game_over: got %b want 0", game_over); end
    wait_collect("match_end_more");
    p1_valid = 1'b1; p1_move = 2'b10;
    p2_valid = 1'b1; p2_move = 2'b01;
    cyc();
    idle_inputs();
    cyc();
    cmp_cnt++; if (matchresult !== 2'b10 || game_over !== 1'b0) begin err_cnt++; $display("FAIL match_end fourth: mr=%b go=%b want 10/0", matchresult, game_over); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_round();
    wait_collect("basic");
    test_draw();
    test_first_move_wins();
    test_timeout();
    test_none_move();
    test_reset_mid();
    test_match_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
